// File: rtl/cpu_bus_arbiter_if.sv
// rtl/cpu_bus_arbiter_if.sv - requester-side and external-bus signal bundle for the arbiter
interface cpu_bus_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 20,
    parameter int DW  = 16
);
    logic [NCH*AW-1:0] m_adr_i;
    logic [NCH*DW-1:0] m_dat_i;
    logic [NCH-1:0]    m_we_i;
    logic [NCH-1:0]    m_mio_i;
    logic [NCH-1:0]    m_byte_i;
    logic [NCH-1:0]    m_stb_i;
    logic [NCH-1:0]    m_lock_i;
    logic [DW-1:0]     m_dat_o;
    logic [NCH-1:0]    m_ack_o;
    logic [NCH-1:0]    m_err_o;
    logic [NCH-1:0]    gnt_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic              s_we_o;
    logic              s_mio_o;
    logic              s_byte_o;
    logic              s_stb_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i;

    // The arbiter takes the slave view; requesters plus the external bus take the master view.
    modport slave (
        input  m_adr_i, m_dat_i, m_we_i, m_mio_i, m_byte_i, m_stb_i, m_lock_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, gnt_o,
        output s_adr_o, s_dat_o, s_we_o, s_mio_o, s_byte_o, s_stb_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_we_i, m_mio_i, m_byte_i, m_stb_i, m_lock_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, gnt_o,
        input  s_adr_o, s_dat_o, s_we_o, s_mio_o, s_byte_o, s_stb_o
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - NCH-way arbiter for the CPU memory/IO bus with lock and timeout
module cpu_bus_arbiter #(
    parameter int NCH       = 2,
    parameter int AW        = 20,
    parameter int DW        = 16,
    parameter int PRIO_MODE = 0,
    parameter int TMO       = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cpu_bus_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   g_idx;
    logic [NCH-1:0]  win;
    logic            busy, stb_g, lock_g, ack_v, tmo_hit;
    logic [AW-1:0]   adr_c;
    logic [DW-1:0]   dat_c;
    logic            we_c, mio_c, byte_c;

    assign busy    = (state_q == BUSY);
    assign stb_g   = busy && |(bus.m_stb_i & gnt_q);
    assign lock_g  = |(bus.m_lock_i & gnt_q);
    assign ack_v   = stb_g && bus.s_ack_i;
    // An ack in the same cycle as the counter limit takes precedence over the error.
    assign tmo_hit = (TMO != 0) && stb_g && !bus.s_ack_i && (cnt_q == CW'(TMO));

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_q[k]) g_idx = IW'(k);
        end
    end

    // Scan in reverse so the highest-priority candidate is the last one written.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        if (PRIO_MODE == 0) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (bus.m_stb_i[k]) begin
                    win    = '0;
                    win[k] = 1'b1;
                end
            end
        end else begin
            for (int i = NCH; i >= 1; i--) begin
                idx = (int'(rr_q) + i) % NCH;
                if (bus.m_stb_i[idx]) begin
                    win      = '0;
                    win[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|bus.m_stb_i) begin
                    state_d = BUSY;
                    gnt_d   = win;
                end
            end
            BUSY: begin
                if (!stb_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (bus.s_ack_i) begin
                    rr_d  = g_idx;
                    cnt_d = '0;
                    if (!lock_g) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    rr_d    = g_idx;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= IW'(NCH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // AND-OR mux on the registered grant; an empty grant yields all zeros.
    always_comb begin
        adr_c  = '0;
        dat_c  = '0;
        we_c   = 1'b0;
        mio_c  = 1'b0;
        byte_c = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_q[k]) begin
                adr_c  = adr_c | bus.m_adr_i[k*AW +: AW];
                dat_c  = dat_c | bus.m_dat_i[k*DW +: DW];
                we_c   = we_c | bus.m_we_i[k];
                mio_c  = mio_c | bus.m_mio_i[k];
                byte_c = byte_c | bus.m_byte_i[k];
            end
        end
    end

    assign bus.s_adr_o  = rst_i ? adr_c : '0;
    assign bus.s_dat_o  = rst_i ? dat_c : '0;
    assign bus.s_we_o   = rst_i && we_c;
    assign bus.s_mio_o  = rst_i && mio_c;
    assign bus.s_byte_o = rst_i && byte_c;
    assign bus.s_stb_o  = rst_i && stb_g && !tmo_hit;
    assign bus.m_ack_o  = (rst_i && ack_v) ? gnt_q : '0;
    assign bus.m_err_o  = (rst_i && tmo_hit) ? gnt_q : '0;
    assign bus.m_dat_o  = bus.s_dat_i;
    assign bus.gnt_o    = gnt_q;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed bench for the CPU bus arbiter, fixed and round-robin variants
module tb_cpu_bus_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cpu_bus_arbiter_if #(.NCH(2), .AW(20), .DW(16)) a ();
    cpu_bus_arbiter_if #(.NCH(3), .AW(20), .DW(16)) b ();

    cpu_bus_arbiter #(.NCH(2), .AW(20), .DW(16), .PRIO_MODE(0), .TMO(4)) u_fix (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a)
    );

    cpu_bus_arbiter #(.NCH(3), .AW(20), .DW(16), .PRIO_MODE(1), .TMO(4)) u_rr (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rr_exp [4];
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        a.m_adr_i = '0; a.m_dat_i = '0; a.m_we_i = '0; a.m_mio_i = '0; a.m_byte_i = '0;
        a.m_stb_i = '0; a.m_lock_i = '0; a.s_dat_i = '0; a.s_ack_i = 1'b0;
        b.m_adr_i = '0; b.m_dat_i = '0; b.m_we_i = '0; b.m_mio_i = '0; b.m_byte_i = '0;
        b.m_stb_i = '0; b.m_lock_i = '0; b.s_dat_i = '0; b.s_ack_i = 1'b0;

        tick();
        tick();
        #1;
        chk("rst_gnt", a.gnt_o, 2'b00);
        chk("rst_stb", a.s_stb_o, 1'b0);
        chk("rst_ack", a.m_ack_o, 2'b00);
        chk("rst_err", a.m_err_o, 2'b00);
        chk("rst_adr", a.s_adr_o, 20'h0);
        chk("rst_gnt_rr", b.gnt_o, 3'b000);
        rst = 1'b1;
        tick();

        a.m_adr_i = {20'h0, 20'h12345};
        a.m_mio_i = 2'b01;
        a.m_stb_i = 2'b01;
        #1;
        chk("t1_latency_stb", a.s_stb_o, 1'b0);
        tick();
        #1;
        chk("t1_gnt", a.gnt_o, 2'b01);
        chk("t1_stb", a.s_stb_o, 1'b1);
        chk("t1_adr", a.s_adr_o, 20'h12345);
        chk("t1_mio", a.s_mio_o, 1'b1);
        chk("t1_noack", a.m_ack_o, 2'b00);
        tick();
        a.s_ack_i = 1'b1;
        a.s_dat_i = 16'hBEEF;
        #1;
        chk("t1_ack", a.m_ack_o, 2'b01);
        chk("t1_rdata", a.m_dat_o, 16'hBEEF);
        tick();
        a.m_stb_i = 2'b00;
        a.s_ack_i = 1'b0;
        #1;
        chk("t1_idle_gnt", a.gnt_o, 2'b00);
        chk("t1_idle_stb", a.s_stb_o, 1'b0);

        a.m_adr_i = {20'h54321, 20'h12345};
        a.m_stb_i = 2'b11;
        a.s_ack_i = 1'b1;
        #1;
        chk("t2_idle_ack_ignored", a.m_ack_o, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("t2_gnt_ch0", a.gnt_o, 2'b01);
            chk("t2_ack_ch0", a.m_ack_o, 2'b01);
            tick();
            #1;
            chk("t2_idle_gap", a.gnt_o, 2'b00);
        end
        a.m_stb_i = 2'b00;
        a.s_ack_i = 1'b0;
        tick();

        a.m_adr_i = {20'h000A0, 20'h12345};
        a.m_dat_i = {16'h1111, 16'h0000};
        a.m_we_i = 2'b10;
        a.m_stb_i = 2'b10;
        a.m_lock_i = 2'b10;
        tick();
        #1;
        chk("t4_gnt1", a.gnt_o, 2'b10);
        chk("t4_stb1", a.s_stb_o, 1'b1);
        chk("t4_adr1", a.s_adr_o, 20'h000A0);
        chk("t4_we1", a.s_we_o, 1'b1);
        chk("t4_dat1", a.s_dat_o, 16'h1111);
        a.s_ack_i = 1'b1;
        a.m_stb_i = 2'b11;
        #1;
        chk("t4_ack1", a.m_ack_o, 2'b10);
        tick();
        a.m_adr_i = {20'h000A2, 20'h12345};
        a.m_lock_i = 2'b00;
        #1;
        chk("t4_gnt2", a.gnt_o, 2'b10);
        chk("t4_stb2", a.s_stb_o, 1'b1);
        chk("t4_adr2", a.s_adr_o, 20'h000A2);
        chk("t4_ack2", a.m_ack_o, 2'b10);
        tick();
        a.m_stb_i = 2'b01;
        a.s_ack_i = 1'b0;
        #1;
        chk("t4_released", a.gnt_o, 2'b00);
        tick();
        #1;
        chk("t4_ch0_gnt", a.gnt_o, 2'b01);
        chk("t4_ch0_adr", a.s_adr_o, 20'h12345);
        chk("t4_ch0_we", a.s_we_o, 1'b0);
        a.s_ack_i = 1'b1;
        tick();
        a.m_stb_i = 2'b00;
        a.s_ack_i = 1'b0;
        a.m_we_i = 2'b00;
        tick();

        a.m_stb_i = 2'b01;
        tick();
        #1;
        chk("t5_stb_rise", a.s_stb_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("t5_no_err", a.m_err_o, 2'b00);
            chk("t5_stb_held", a.s_stb_o, 1'b1);
        end
        tick();
        #1;
        chk("t5_err", a.m_err_o, 2'b01);
        chk("t5_stb_forced", a.s_stb_o, 1'b0);
        tick();
        #1;
        chk("t5_idle_gnt", a.gnt_o, 2'b00);
        chk("t5_err_pulse", a.m_err_o, 2'b00);
        tick();
        for (int i = 0; i < 4; i++) tick();
        a.s_ack_i = 1'b1;
        #1;
        chk("t5_ack_wins", a.m_ack_o, 2'b01);
        chk("t5_no_err_on_ack", a.m_err_o, 2'b00);
        chk("t5_stb_on_ack", a.s_stb_o, 1'b1);
        tick();
        a.m_stb_i = 2'b00;
        a.s_ack_i = 1'b0;
        #1;
        chk("t5_done", a.gnt_o, 2'b00);

        b.m_stb_i = 3'b111;
        b.s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("t3_rr_gnt", b.gnt_o, rr_exp[i]);
            chk("t3_rr_ack", b.m_ack_o, rr_exp[i]);
            tick();
            #1;
            chk("t3_rr_idle", b.gnt_o, 3'b000);
        end
        b.m_stb_i = 3'b000;
        b.s_ack_i = 1'b0;
        tick();

        b.m_stb_i = 3'b010;
        tick();
        #1;
        chk("t6_busy", b.s_stb_o, 1'b1);
        rst = 1'b0;
        tick();
        #1;
        chk("t6_rst_gnt", b.gnt_o, 3'b000);
        chk("t6_rst_stb", b.s_stb_o, 1'b0);
        chk("t6_rst_ack", b.m_ack_o, 3'b000);
        rst = 1'b1;
        b.m_stb_i = 3'b111;
        tick();
        #1;
        chk("t6_ch0_first", b.gnt_o, 3'b001);
        b.m_stb_i = 3'b000;
        b.s_ack_i = 1'b1;
        #1;
        chk("t6_abort_noack", b.m_ack_o, 3'b000);
        tick();
        b.s_ack_i = 1'b0;
        #1;
        chk("t6_abort_idle", b.gnt_o, 3'b000);
        b.m_stb_i = 3'b111;
        tick();
        #1;
        chk("t6_abort_rr_kept", b.gnt_o, 3'b001);
        b.m_stb_i = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
